// File: rtl/processor_defs.sv
// Shared processor definitions: opcode constants, instruction field positions
// and the write-back sequencer state encoding.
package processor_defs;

    localparam int unsigned OPCODE_W   = 5;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 27;
    localparam int unsigned RD_MSB     = 26;
    localparam int unsigned RD_LSB     = 22;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_LW         = 5'd0;
    localparam opcode_t OP_SW         = 5'd1;
    localparam opcode_t OP_DATA_FIRST = 5'd2;
    localparam opcode_t OP_DATA_LAST  = 5'd18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        WRITE = 2'd2
    } wb_state_t;

    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_data_op(input opcode_t op);
        return (op >= OP_DATA_FIRST) && (op <= OP_DATA_LAST);
    endfunction

endpackage

// File: rtl/wb_mem_timer.sv
// Memory-wait timer: counts MEM cycles without ack and flags the cycle on
// which the wait limit is reached.
module wb_mem_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic wait_cycle,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // count holds the number of ack-less MEM cycles already elapsed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wait_cycle) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = wait_cycle && (count == LAST);

endmodule

// File: rtl/writeback_sequencer.sv
// Write-back stage sequencer: accepts one retiring instruction, runs LW/SW on
// the data-memory port, then writes the register file. Optional WB_TIMEOUT_EN.
module writeback_sequencer
    import processor_defs::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     instruction,
    input  logic [DATA_WIDTH-1:0]     in,
    input  logic [DATA_WIDTH-1:0]     store_data,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      retired,
    output logic                      mem_timeout
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    wb_state_t                 state;
    opcode_t                   opcode_q;
    opcode_t                   in_opcode;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic                      timer_expired_c;
    logic                      unused_instr_bits;

    assign in_opcode         = instruction[OPCODE_MSB:OPCODE_LSB];
    assign in_rd             = REG_ADDR_WIDTH'(instruction[RD_MSB:RD_LSB]);
    assign unused_instr_bits = ^instruction[RD_LSB-1:0];

`ifdef WB_TIMEOUT_EN
    logic mem_enter_c;
    logic mem_wait_c;
    logic timeout_q;

    assign mem_enter_c = (state == IDLE) && in_valid && is_mem_op(in_opcode);
    assign mem_wait_c  = (state == MEM) && !mem_ack;

    wb_mem_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (mem_enter_c),
        .wait_cycle (mem_wait_c),
        .expired_c  (timer_expired_c)
    );

    assign mem_timeout = timeout_q;
`else
    assign timer_expired_c = 1'b0;
    assign mem_timeout     = 1'b0;
`endif

    // Sequencer FSM with registered handshake, memory and register-file outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            opcode_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            retired   <= 1'b0;
`ifdef WB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            rf_we   <= 1'b0;
            retired <= 1'b0;
`ifdef WB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opcode_q  <= in_opcode;
                        rf_waddr  <= in_rd;
                        rf_wdata  <= in;
                        mem_addr  <= in;
                        mem_wdata <= store_data;
                        if (is_mem_op(in_opcode)) begin
                            state    <= MEM;
                            in_ready <= 1'b0;
                            mem_req  <= 1'b1;
                            mem_we   <= (in_opcode == OP_SW);
                        end else if (is_data_op(in_opcode)) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            rf_we    <= (in_rd != '0);
                            retired  <= 1'b1;
                        end else begin
                            retired  <= 1'b1;
                        end
                    end
                end
                MEM: begin
                    // ack takes priority over an expiring wait on the same cycle
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        retired <= 1'b1;
                        if (opcode_q == OP_LW) begin
                            state    <= WRITE;
                            rf_we    <= (rf_waddr != '0);
                            rf_wdata <= mem_rdata;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end else if (timer_expired_c) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        retired  <= 1'b1;
                        state    <= IDLE;
                        in_ready <= 1'b1;
`ifdef WB_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end
                end
                WRITE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Randomized self-checking bench for writeback_sequencer; expected behaviour is
// derived per transaction from the opcode class, rd and the memory response.
module tb_writeback_sequencer;

    localparam int TO = 4;
`ifdef WB_TIMEOUT_EN
    localparam int MAX_DLY = TO - 1;
`else
    localparam int MAX_DLY = 6;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] alu_in;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retired;
    logic        mem_timeout;

    int n_vec = 0;
    int n_err = 0;

    writeback_sequencer #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .in          (alu_in),
        .store_data  (store_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .retired     (retired),
        .mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=still running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One instruction from acceptance to completion; starts and ends just after a negedge
    task automatic run_txn(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] sdat, input int ack_dly, input logic [31:0] rdat,
                           input logic never_ack);
        logic is_mem;
        logic is_data;
        logic ack_now;
        int   n_mem;
        is_mem  = (op == 5'd0) || (op == 5'd1);
        is_data = (op >= 5'd2) && (op <= 5'd18);
        check("accept_ready", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        instruction = {op, rd, 22'($urandom)};
        alu_in      = alu;
        store_data  = sdat;
        mem_ack     = 1'($urandom);
        mem_rdata   = $urandom;
        @(negedge clk);
        in_valid    = 1'b0;
        instruction = $urandom;
        alu_in      = $urandom;
        store_data  = $urandom;
        mem_ack     = 1'b0;
        if (is_mem) begin
            n_mem = never_ack ? TO : ack_dly + 1;
            for (int k = 0; k < n_mem; k++) begin
                check("mem_req", 32'(mem_req), 32'd1);
                check("mem_we", 32'(mem_we), 32'(op == 5'd1));
                check("mem_addr", mem_addr, alu);
                if (op == 5'd1) check("mem_wdata", mem_wdata, sdat);
                check("mem_busy_ready", 32'(in_ready), 32'd0);
                check("mem_rf_we", 32'(rf_we), 32'd0);
                check("mem_retired", 32'(retired), 32'd0);
                ack_now   = !never_ack && (k == ack_dly);
                mem_ack   = ack_now;
                mem_rdata = ack_now ? rdat : $urandom;
                @(negedge clk);
            end
            mem_ack = 1'b0;
            check("post_mem_req", 32'(mem_req), 32'd0);
            check("post_mem_retired", 32'(retired), 32'd1);
            if (never_ack) begin
                check("timeout_pulse", 32'(mem_timeout), 32'd1);
                check("timeout_rf_we", 32'(rf_we), 32'd0);
                check("timeout_ready", 32'(in_ready), 32'd1);
            end else if (op == 5'd0) begin
                check("lw_timeout", 32'(mem_timeout), 32'd0);
                check("lw_rf_we", 32'(rf_we), 32'(rd != 5'd0));
                if (rd != 5'd0) begin
                    check("lw_waddr", 32'(rf_waddr), 32'(rd));
                    check("lw_wdata", rf_wdata, rdat);
                end
                check("lw_write_ready", 32'(in_ready), 32'd0);
                @(negedge clk);
                check("lw_done_ready", 32'(in_ready), 32'd1);
            end else begin
                check("sw_timeout", 32'(mem_timeout), 32'd0);
                check("sw_rf_we", 32'(rf_we), 32'd0);
                check("sw_ready", 32'(in_ready), 32'd1);
            end
        end else if (is_data) begin
            check("dat_rf_we", 32'(rf_we), 32'(rd != 5'd0));
            if (rd != 5'd0) begin
                check("dat_waddr", 32'(rf_waddr), 32'(rd));
                check("dat_wdata", rf_wdata, alu);
            end
            check("dat_retired", 32'(retired), 32'd1);
            check("dat_mem_req", 32'(mem_req), 32'd0);
            check("dat_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            check("dat_done_ready", 32'(in_ready), 32'd1);
        end else begin
            check("nop_retired", 32'(retired), 32'd1);
            check("nop_rf_we", 32'(rf_we), 32'd0);
            check("nop_mem_req", 32'(mem_req), 32'd0);
            check("nop_ready", 32'(in_ready), 32'd1);
        end
        // idle gap: pulses must have dropped and stray acks are ignored
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        check("gap_retired", 32'(retired), 32'd0);
        check("gap_rf_we", 32'(rf_we), 32'd0);
        check("gap_mem_req", 32'(mem_req), 32'd0);
        check("gap_timeout", 32'(mem_timeout), 32'd0);
        check("gap_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [4:0] op;
        logic [4:0] rd;
        int         cls;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = '0;
        alu_in      = '0;
        store_data  = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(5'd5, 5'd3, 32'hDEADBEEF, 32'h0, 0, 32'h0, 1'b0);
        run_txn(5'd0, 5'd7, 32'h100, 32'h0, 2, 32'h8F38FAAA, 1'b0);
        run_txn(5'd1, 5'd9, 32'h40, 32'h1234, 0, 32'h0, 1'b0);
        run_txn(5'd31, 5'd4, 32'h55, 32'h0, 0, 32'h0, 1'b0);
        run_txn(5'd9, 5'd0, 32'h77, 32'h0, 0, 32'h0, 1'b0);
        run_txn(5'd0, 5'd0, 32'h200, 32'h0, 1, 32'hCAFEF00D, 1'b0);
        run_txn(5'd18, 5'd31, 32'h1, 32'h0, 0, 32'h0, 1'b0);
        run_txn(5'd19, 5'd31, 32'h2, 32'h0, 0, 32'h0, 1'b0);

        // reset during a memory wait
        in_valid    = 1'b1;
        instruction = {5'd0, 5'd12, 22'h0};
        alu_in      = 32'h300;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstmid_req_pre", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rstmid_req_async", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        check("rstmid_ready", 32'(in_ready), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hBADBAD00;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_rf_we", 32'(rf_we), 32'd0);
        check("late_ack_retired", 32'(retired), 32'd0);
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_ready", 32'(in_ready), 32'd1);

`ifdef WB_TIMEOUT_EN
        run_txn(5'd0, 5'd5, 32'h400, 32'h0, 0, 32'h0, 1'b1);
        run_txn(5'd1, 5'd5, 32'h404, 32'h99, 0, 32'h0, 1'b1);
        run_txn(5'd0, 5'd6, 32'h408, 32'h0, TO - 1, 32'h13579BDF, 1'b0);
`endif

        for (int i = 0; i < 300; i++) begin
            cls = int'($urandom_range(0, 3));
            case (cls)
                0:       op = 5'($urandom_range(0, 1));
                1, 2:    op = 5'($urandom_range(2, 18));
                default: op = 5'($urandom_range(19, 31));
            endcase
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            run_txn(op, rd, $urandom, $urandom, int'($urandom_range(0, MAX_DLY)), $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
